sort_sequencer: RTL and testbench

//   Sequencing controller for the serial sort datapath: collects NUM_ELEMS unsigned words

---
 rtl/sort_sequencer.sv | 132 +++++++++++++
 tb/tb_sort_sequencer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/sort_sequencer.sv
// Serial sort sequencer: loads num_elems words, bubble-sorts them with one
// compare-exchange per clock, then streams them out smallest first.
module sort_sequencer #(
  parameter int unsigned data_width = 3,
  parameter int unsigned num_elems  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [data_width-1:0]           in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [data_width-1:0]           out_data,
  output logic [num_elems*data_width-1:0] outp,
  output logic [num_elems*data_width-1:0] outp_inps,
  output logic                            busy,
  output logic                            done
);

  localparam int unsigned CW = (num_elems > 2) ? $clog2(num_elems) : 1;
  localparam logic [CW-1:0] LAST     = CW'(num_elems - 1);
  localparam logic [CW-1:0] LAST_CMP = CW'(num_elems - 2);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SORT   = 2'd1,
    UNLOAD = 2'd2
  } state_t;

  state_t r_state, w_next;

  logic [data_width-1:0]           r_mem [num_elems];
  logic [data_width-1:0]           w_sorted [num_elems];
  logic [CW-1:0]                   r_load, r_pass, r_idx, r_rd;
  logic [CW-1:0]                   w_idx1;
  logic [num_elems*data_width-1:0] r_outp, r_outp_inps;
  logic                            r_done;
  logic                            w_load_beat, w_out_beat, w_sort_last, w_swap;
  logic [data_width-1:0]           w_a, w_b;

  assign w_load_beat = (r_state == LOAD) && in_valid;
  assign w_out_beat  = (r_state == UNLOAD) && out_ready;
  assign w_sort_last = (r_state == SORT) && (r_pass == LAST_CMP) && (r_idx == LAST_CMP);

  // Compare-exchange on the pair at the current index; equal values stay put.
  assign w_idx1 = r_idx + CW'(1);
  assign w_a    = r_mem[r_idx];
  assign w_b    = r_mem[w_idx1];
  assign w_swap = (r_state == SORT) && (w_a > w_b);

  always_comb begin
    w_sorted = r_mem;
    if (w_swap) begin
      w_sorted[r_idx]  = w_b;
      w_sorted[w_idx1] = w_a;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= LOAD;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      LOAD: begin
        in_ready = 1'b1;
        if (w_load_beat && (r_load == LAST)) w_next = SORT;
      end
      SORT: begin
        busy = 1'b1;
        if (w_sort_last) w_next = UNLOAD;
      end
      UNLOAD: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (w_out_beat && (r_rd == LAST)) w_next = LOAD;
      end
      default: w_next = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < num_elems; k++) r_mem[k] <= '0;
      r_load      <= '0;
      r_pass      <= '0;
      r_idx       <= '0;
      r_rd        <= '0;
      r_outp      <= '0;
      r_outp_inps <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_sort_last;
      if (w_load_beat) begin
        for (int unsigned k = 0; k < num_elems; k++) begin
          if (CW'(k) == r_load) begin
            r_mem[k]                                <= in_data;
            r_outp_inps[k*data_width +: data_width] <= in_data;
          end
        end
        r_load <= (r_load == LAST) ? '0 : r_load + CW'(1);
      end
      if (r_state == SORT) begin
        r_mem <= w_sorted;
        if (r_idx == LAST_CMP) begin
          r_idx  <= '0;
          r_pass <= (r_pass == LAST_CMP) ? '0 : r_pass + CW'(1);
        end else begin
          r_idx <= w_idx1;
        end
        // Capture includes the swap made by the final compare.
        if (w_sort_last) begin
          for (int unsigned k = 0; k < num_elems; k++)
            r_outp[k*data_width +: data_width] <= w_sorted[k];
        end
      end
      if (w_out_beat) r_rd <= (r_rd == LAST) ? '0 : r_rd + CW'(1);
    end
  end

  assign out_data  = r_mem[r_rd];
  assign outp      = r_outp;
  assign outp_inps = r_outp_inps;
  assign done      = r_done;

endmodule

// File: tb/tb_sort_sequencer.sv
// Directed self-checking bench for sort_sequencer (data_width=3, num_elems=4).
module tb_sort_sequencer;

  localparam int DW = 3;
  localparam int N  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DW-1:0]     in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic [N*DW-1:0]   outp;
  logic [N*DW-1:0]   outp_inps;
  logic              busy;
  logic              done;

  int n_checks = 0;
  int n_errors = 0;

  sort_sequencer #(.data_width(DW), .num_elems(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .outp      (outp),
    .outp_inps (outp_inps),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // words: batch in load order, first word in LSBs; exp_outp: hand-sorted batch.
  task automatic run_batch(input logic [N*DW-1:0] words, input bit gaps,
                           input int stall_beat, input bit pulse,
                           input logic [N*DW-1:0] exp_outp);
    int c;
    for (int k = 0; k < N; k++) begin
      if (gaps) begin
        in_valid = 1'b0;
        tick();
        tick();
      end
      check("in_ready_load", in_ready, 1);
      in_valid = 1'b1;
      in_data  = words[k*DW +: DW];
      tick();
      in_valid = 1'b0;
    end
    check("busy_sort", busy, 1);
    check("in_ready_sort", in_ready, 0);
    c = 1;
    while (!done && c < 40) begin
      if (pulse) begin
        in_valid = 1'b1;
        in_data  = 3'd7;
      end
      tick();
      c++;
    end
    in_valid = 1'b0;
    check("sort_cycles", c - 1, 9);
    check("done_set", done, 1);
    check("outp", outp, exp_outp);
    check("outp_inps", outp_inps, words);
    out_ready = 1'b1;
    for (int b = 0; b < N; b++) begin
      if (b == stall_beat) begin
        out_ready = 1'b0;
        repeat (3) begin
          tick();
          check("stall_data", out_data, exp_outp[b*DW +: DW]);
          check("stall_valid", out_valid, 1);
        end
        out_ready = 1'b1;
      end
      check("out_valid", out_valid, 1);
      check("stream", out_data, exp_outp[b*DW +: DW]);
      if (pulse) begin
        in_valid = 1'b1;
        in_data  = 3'd6;
      end
      tick();
      in_valid = 1'b0;
      if (b == 0) check("done_pulse_end", done, 0);
    end
    out_ready = 1'b0;
    check("out_valid_end", out_valid, 0);
    check("in_ready_end", in_ready, 1);
    check("busy_end", busy, 0);
    check("outp_hold", outp, exp_outp);
    check("outp_inps_hold", outp_inps, words);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_done", done, 0);
    check("rst_outp", outp, 0);
    check("rst_outp_inps", outp_inps, 0);
    rst = 1'b0;
    tick();

    // 5,3,7,1 back-to-back
    run_batch(12'h3DD, 1'b0, -1, 1'b0, 12'hF59);
    // already sorted 0,1,2,3
    run_batch(12'h688, 1'b0, -1, 1'b0, 12'h688);
    // duplicates 2,2,2,0 with gaps; in_valid pulsed during SORT/UNLOAD
    run_batch(12'h092, 1'b1, -1, 1'b1, 12'h490);

    // 7,6,5,4 then reset on SORT cycle 4
    for (int k = 0; k < N; k++) begin
      in_valid = 1'b1;
      in_data  = 3'(7 - k);
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    check("pre_rst_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_in_ready", in_ready, 1);
    check("arst_busy", busy, 0);
    check("arst_out_valid", out_valid, 0);
    check("arst_done", done, 0);
    check("arst_out_data", out_data, 0);
    check("arst_outp", outp, 0);
    check("arst_outp_inps", outp_inps, 0);
    #2 rst = 1'b0;
    tick();

    // fresh batch 6,4,0,5 with output stall on the second beat
    run_batch(12'hA26, 1'b0, 1, 1'b0, 12'hD60);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
